// File: rtl/streamtest_pkg.sv
// streamtest_pkg: shared constants and helpers for the stream pattern
// source/checker.
//   - Wishbone register addresses and CTRL bit positions.
//   - Direction and pattern-mode encodings.
//   - LFSR taps/seeds and single-step helpers.
package streamtest_pkg;

  localparam logic [1:0] ADDR_LEN  = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_SEED = 2'd2;
  localparam logic [1:0] ADDR_ERR  = 2'd3;

  localparam int CTRL_DIR  = 31;
  localparam int CTRL_DEV  = 30;
  localparam int CTRL_MODE = 29;

  typedef enum logic {D_SINK = 1'b0, D_SOURCE = 1'b1} dir_t;
  typedef enum logic {M_INCR = 1'b0, M_LFSR = 1'b1} mode_t;

  localparam logic [31:0] LFSR32_TAPS = 32'h8020_0003;
  localparam logic [15:0] LFSR16_SEED = 16'hACE1;
  localparam logic [15:0] LFSR16_TAPS = 16'hB400;

  // Right-shifting Galois steps.
  function automatic logic [31:0] lfsr32_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR32_TAPS) : (v >> 1);
  endfunction

  function automatic logic [15:0] lfsr16_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR16_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/streamtest_pattern.sv
// streamtest_pattern: holds the 32-bit pattern state P and expands it into
// an SW-wide word of 32-bit lanes.
//   clk, reset : clock, synchronous active-high reset (P returns to 1)
//   load, seed : load P from seed (0 becomes 1 in LFSR mode); beats a step
//   step       : advance P by one beat
//   mode       : incr (lane k = P+k) or LFSR (lane k = P ^ k*0x01010101)
//   p, word    : current P and the expanded lane word
module streamtest_pattern
  import streamtest_pkg::*;
#(
  parameter int SW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [31:0]   seed,
  input  logic          step,
  input  mode_t         mode,
  output logic [31:0]   p,
  output logic [SW-1:0] word
);

  localparam int unsigned LANES = SW / 32;

  always_ff @(posedge clk) begin
    if (reset) begin
      p <= 32'd1;
    end else if (load) begin
      p <= (mode == M_LFSR && seed == '0) ? 32'd1 : seed;
    end else if (step) begin
      p <= (mode == M_INCR) ? p + 32'(LANES) : lfsr32_step(p);
    end
  end

  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      word[k*32 +: 32] = (mode == M_INCR) ? p + 32'(k) : p ^ (32'(k) * 32'h0101_0101);
    end
  end

endmodule

// File: rtl/streamtest.sv
// streamtest: AXI-stream pattern source / checking sink behind a Wishbone
// slave.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_wb_*                : pipelined Wishbone slave; regs LEN, CTRL, SEED, ERR
//   o_wb_stall/ack/data   : never stalls; ack and registered data one cycle on
//   S_VALID/S_DATA/S_LAST : sink stream in, S_READY out
//   M_VALID/M_DATA/M_LAST : source stream out, M_READY in
//   o_dev                 : CTRL.dev
//   o_err                 : sticky error (set until a transfer is armed)
//   o_done                : armed transfer completed
module streamtest
  import streamtest_pkg::*;
#(
  parameter int SW           = 32,
  parameter int LGLEN        = 20,
  parameter bit OPT_THROTTLE = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [1:0]    i_wb_addr,
  input  logic [31:0]   i_wb_data,
  input  logic [3:0]    i_wb_sel,
  output logic          o_wb_stall,
  output logic          o_wb_ack,
  output logic [31:0]   o_wb_data,
  input  logic          S_VALID,
  input  logic [SW-1:0] S_DATA,
  input  logic          S_LAST,
  output logic          S_READY,
  output logic          M_VALID,
  output logic [SW-1:0] M_DATA,
  output logic          M_LAST,
  input  logic          M_READY,
  output logic          o_dev,
  output logic          o_err,
  output logic          o_done
);

  localparam int LGB = $clog2(SW / 8);

  dir_t             dir;
  mode_t            mode;
  logic             dev;
  logic [7:0]       thr;
  logic             armed;
  logic [LGLEN-1:0] len;
  logic [LGLEN-1:0] beat_idx;
  logic [15:0]      errcnt;
  logic [15:0]      first_err;
  logic             err_flag;
  logic             done;
  logic             zero_pend;
  logic             m_hold;
  logic             gate;
  logic [31:0]      pat_p;
  logic [SW-1:0]    pat_word;
  logic [31:0]      rd;
  logic [31:0]      rem_bytes;
  logic             unused_sel;

  wire wb_req  = i_wb_cyc && i_wb_stb;
  wire wb_wr   = wb_req && i_wb_we;
  wire len_wr  = wb_wr && (i_wb_addr == ADDR_LEN);
  wire ctrl_wr = wb_wr && (i_wb_addr == ADDR_CTRL);
  wire seed_wr = wb_wr && (i_wb_addr == ADDR_SEED);

  wire [LGLEN-1:0] len_new = LGLEN'(i_wb_data >> LGB);
  wire len_nz    = (len != '0);
  wire last_beat = (len == LGLEN'(1));

  generate
    if (OPT_THROTTLE) begin : g_thr
      logic [15:0] lfsr;
      always_ff @(posedge i_clk) begin
        if (i_reset) lfsr <= LFSR16_SEED;
        else         lfsr <= lfsr16_step(lfsr);
      end
      assign gate = (lfsr[7:0] >= thr);
    end else begin : g_nothr
      assign gate = 1'b1;
    end
  endgenerate

  // Valid may only rise on an open gate; m_hold keeps it up until accepted.
  wire src_go = armed && (dir == D_SOURCE) && len_nz;
  assign M_VALID = src_go && (gate || m_hold);
  assign M_DATA  = M_VALID ? pat_word : '0;
  assign M_LAST  = M_VALID && last_beat;
  assign S_READY = armed && (dir == D_SINK) && len_nz && gate;

  wire s_acc = S_VALID && S_READY;
  wire m_acc = M_VALID && M_READY;
  // A LEN write in the same cycle discards the beat entirely.
  wire beat     = (s_acc || m_acc) && !len_wr;
  wire beat_bad = s_acc && ((S_DATA != pat_word) || (S_LAST != last_beat));
  wire extra    = S_VALID && ((dir == D_SOURCE) || (armed && !len_nz));
  wire err_evt  = !len_wr && (beat_bad || extra);

  streamtest_pattern #(.SW(SW)) u_pattern (
    .clk   (i_clk),
    .reset (i_reset),
    .load  (seed_wr),
    .seed  (i_wb_data),
    .step  (beat),
    .mode  (mode),
    .p     (pat_p),
    .word  (pat_word)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dir       <= D_SINK;
      mode      <= M_INCR;
      dev       <= 1'b0;
      thr       <= '0;
      armed     <= 1'b0;
      len       <= '0;
      beat_idx  <= '0;
      errcnt    <= '0;
      first_err <= '0;
      err_flag  <= 1'b1;
      done      <= 1'b0;
      zero_pend <= 1'b0;
      m_hold    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        if (i_wb_sel[3]) begin
          dir  <= i_wb_data[CTRL_DIR] ? D_SOURCE : D_SINK;
          dev  <= i_wb_data[CTRL_DEV];
          mode <= i_wb_data[CTRL_MODE] ? M_LFSR : M_INCR;
        end
        if (i_wb_sel[0]) thr <= i_wb_data[7:0];
      end

      if (len_wr) begin
        armed     <= 1'b1;
        len       <= len_new;
        beat_idx  <= '0;
        errcnt    <= '0;
        first_err <= '0;
        err_flag  <= 1'b0;
        done      <= 1'b0;
        zero_pend <= (len_new == '0);
        m_hold    <= 1'b0;
      end else begin
        zero_pend <= 1'b0;
        m_hold    <= M_VALID && !M_READY;
        if (zero_pend) done <= 1'b1;
        if (beat) begin
          len      <= len - LGLEN'(1);
          beat_idx <= beat_idx + LGLEN'(1);
          if (last_beat) done <= 1'b1;
        end
        if (err_evt) begin
          err_flag <= 1'b1;
          if (errcnt != 16'hFFFF) errcnt <= errcnt + 16'd1;
          if (errcnt == '0) first_err <= 16'(beat_idx);
        end
      end
    end
  end

  assign rem_bytes = 32'(len) << LGB;

  always_comb begin
    rd = '0;
    case (i_wb_addr)
      ADDR_LEN:  rd = {dir == D_SOURCE, armed && len_nz, rem_bytes[29:0]};
      ADDR_CTRL: rd = {dir == D_SOURCE, dev, mode == M_LFSR, 21'b0, thr};
      ADDR_SEED: rd = pat_p;
      ADDR_ERR:  rd = {errcnt, first_err};
      default:   rd = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack  <= wb_req;
      o_wb_data <= wb_req ? rd : '0;
    end
  end

  assign o_wb_stall = 1'b0;
  assign o_dev      = dev;
  assign o_err      = err_flag;
  assign o_done     = done;
  assign unused_sel = ^i_wb_sel[2:1];

endmodule

// File: tb/tb_streamtest.sv
module tb_streamtest;

  typedef logic [128:0] v_t;

  localparam logic [1:0] A_LEN = 2'd0, A_CTRL = 2'd1, A_SEED = 2'd2, A_ERR = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic wb_cyc, wb_we;
  logic [2:0] stb;
  logic [1:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0] wb_sel;

  // SW=128 instance
  logic w_stall, w_ack, w_mvalid, w_mlast, w_sready, w_dev, w_err, w_done, w_mready;
  logic [31:0] w_rd;
  logic [127:0] w_mdata;
  // SW=32 main instance
  logic d_stall, d_ack, d_mvalid, d_mlast, d_sready, d_dev, d_err, d_done, d_mready;
  logic [31:0] d_rd, d_mdata, sd;
  logic sv, sl, bm_ready, loop;
  // SW=32 loopback sink peer
  logic p_stall, p_ack, p_mvalid, p_mlast, p_sready, p_dev, p_err, p_done, p_svalid;
  logic [31:0] p_rd, p_mdata;

  assign d_mready = loop ? p_sready : bm_ready;
  assign p_svalid = loop & d_mvalid;

  streamtest #(.SW(128), .LGLEN(20), .OPT_THROTTLE(1'b1)) u_w (
    .i_clk(clk), .i_reset(rst_a), .i_wb_cyc(wb_cyc), .i_wb_stb(stb[0]), .i_wb_we(wb_we),
    .i_wb_addr(wb_addr), .i_wb_data(wb_wdata), .i_wb_sel(wb_sel),
    .o_wb_stall(w_stall), .o_wb_ack(w_ack), .o_wb_data(w_rd),
    .S_VALID(1'b0), .S_DATA(128'b0), .S_LAST(1'b0), .S_READY(w_sready),
    .M_VALID(w_mvalid), .M_DATA(w_mdata), .M_LAST(w_mlast), .M_READY(w_mready),
    .o_dev(w_dev), .o_err(w_err), .o_done(w_done));

  streamtest #(.SW(32), .LGLEN(20), .OPT_THROTTLE(1'b1)) u_d (
    .i_clk(clk), .i_reset(rst_a), .i_wb_cyc(wb_cyc), .i_wb_stb(stb[1]), .i_wb_we(wb_we),
    .i_wb_addr(wb_addr), .i_wb_data(wb_wdata), .i_wb_sel(wb_sel),
    .o_wb_stall(d_stall), .o_wb_ack(d_ack), .o_wb_data(d_rd),
    .S_VALID(sv), .S_DATA(sd), .S_LAST(sl), .S_READY(d_sready),
    .M_VALID(d_mvalid), .M_DATA(d_mdata), .M_LAST(d_mlast), .M_READY(d_mready),
    .o_dev(d_dev), .o_err(d_err), .o_done(d_done));

  streamtest #(.SW(32), .LGLEN(20), .OPT_THROTTLE(1'b1)) u_p (
    .i_clk(clk), .i_reset(rst_b), .i_wb_cyc(wb_cyc), .i_wb_stb(stb[2]), .i_wb_we(wb_we),
    .i_wb_addr(wb_addr), .i_wb_data(wb_wdata), .i_wb_sel(wb_sel),
    .o_wb_stall(p_stall), .o_wb_ack(p_ack), .o_wb_data(p_rd),
    .S_VALID(p_svalid), .S_DATA(d_mdata), .S_LAST(d_mlast), .S_READY(p_sready),
    .M_VALID(p_mvalid), .M_DATA(p_mdata), .M_LAST(p_mlast), .M_READY(1'b0),
    .o_dev(p_dev), .o_err(p_err), .o_done(p_done));

  int checks = 0;
  int failures = 0;
  v_t sb[$];
  logic [31:0] rq[$];

  function automatic logic [31:0] m_lfsr(input logic [31:0] v);
    logic [31:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  task automatic chk(input string tag, input v_t obs, input v_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input int unsigned w, input logic [1:0] a, input logic [31:0] d);
    wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdata = d; wb_sel = 4'hF;
    stb = 3'(1 << w);
    @(negedge clk);
    wb_cyc = 1'b0; wb_we = 1'b0; stb = '0;
  endtask

  task automatic wb_read_chk(input int unsigned w, input logic [1:0] a, input logic [31:0] exp,
                             input string tag);
    logic [31:0] obs;
    logic ack;
    rq.push_back(exp);
    wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = a; wb_sel = 4'hF;
    stb = 3'(1 << w);
    @(negedge clk);
    wb_cyc = 1'b0; stb = '0;
    case (w)
      0: begin obs = w_rd; ack = w_ack; end
      1: begin obs = d_rd; ack = d_ack; end
      default: begin obs = p_rd; ack = p_ack; end
    endcase
    chk({tag, "_ack"}, v_t'(ack), v_t'(1));
    chk(tag, v_t'(obs), v_t'(rq.pop_front()));
  endtask

  task automatic s_beat(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    sv = 1'b1; sd = d; sl = l;
    while (!d_sready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("s_ready_timeout", v_t'(d_sready), v_t'(1));
    @(negedge clk);
    sv = 1'b0;
  endtask

  initial begin
    logic [31:0] p;
    v_t e, prev_md;
    logic prev_hold;
    int cyc;

    rst_a = 1'b1; rst_b = 1'b1;
    wb_cyc = 1'b0; wb_we = 1'b0; stb = '0; wb_addr = '0; wb_wdata = '0; wb_sel = '0;
    sv = 1'b0; sd = '0; sl = 1'b0; bm_ready = 1'b0; loop = 1'b0; w_mready = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    repeat (5) @(negedge clk);
    rst_b = 1'b0;

    // Reset state
    chk("rst_err", v_t'(d_err), v_t'(1));
    chk("rst_done", v_t'(d_done), v_t'(0));
    chk("rst_mvalid", v_t'(d_mvalid), v_t'(0));
    chk("rst_sready", v_t'(d_sready), v_t'(0));
    chk("rst_ack", v_t'(d_ack), v_t'(0));
    chk("rst_rdata", v_t'(d_rd), v_t'(0));
    wb_read_chk(1, A_LEN, 32'h0, "rst_len");
    wb_read_chk(1, A_CTRL, 32'h0, "rst_ctrl");
    wb_read_chk(1, A_SEED, 32'h1, "rst_seed");
    wb_read_chk(1, A_ERR, 32'h0, "rst_errreg");
    chk("rd_idle", v_t'(d_rd), v_t'(0));

    // SW=128 source, incr, seed 0x10, 64 bytes, full rate
    p = 32'h10;
    for (int b = 0; b < 4; b++) begin
      e = '0;
      for (int k = 0; k < 4; k++) e[k*32 +: 32] = p + 32'(k);
      e[128] = (b == 3);
      sb.push_back(e);
      p = p + 32'd4;
    end
    w_mready = 1'b1;
    wb_write(0, A_CTRL, 32'h8000_0000);
    wb_write(0, A_SEED, 32'h10);
    wb_write(0, A_LEN, 32'd64);
    for (int b = 0; b < 4; b++) begin
      chk("src128_valid", v_t'(w_mvalid), v_t'(1));
      if (w_mvalid) chk("src128_beat", v_t'({w_mlast, w_mdata}), sb.pop_front());
      @(negedge clk);
    end
    chk("src128_idle", v_t'(w_mvalid), v_t'(0));
    chk("src128_done", v_t'(w_done), v_t'(1));
    chk("src128_err", v_t'(w_err), v_t'(0));
    wb_read_chk(0, A_LEN, 32'h8000_0000, "src128_lenreg");
    wb_read_chk(0, A_SEED, 32'h20, "src128_p");
    sb.delete();

    // Sub-beat length rounds to zero beats: done follows one cycle later
    wb_write(0, A_LEN, 32'd12);
    chk("zero_len_done0", v_t'(w_done), v_t'(0));
    @(negedge clk);
    chk("zero_len_done1", v_t'(w_done), v_t'(1));
    chk("zero_len_valid", v_t'(w_mvalid), v_t'(0));
    w_mready = 1'b0;

    // Loopback: u_d source -> u_p sink, LFSR, seed 0, 1024 bytes, T=0x80
    loop = 1'b1;
    wb_write(2, A_CTRL, 32'h2000_0080);
    wb_write(2, A_SEED, 32'h0);
    wb_write(2, A_LEN, 32'd1024);
    wb_write(1, A_CTRL, 32'hA000_0080);
    wb_write(1, A_SEED, 32'h0);
    p = 32'h1;
    for (int b = 0; b < 256; b++) begin
      sb.push_back({1'(b == 255), 96'b0, p});
      p = m_lfsr(p);
    end
    wb_write(1, A_LEN, 32'd1024);
    prev_hold = 1'b0;
    prev_md = '0;
    cyc = 0;
    while (sb.size() != 0 && cyc < 20000) begin
      if (prev_hold) begin
        chk("lb_hold_valid", v_t'(d_mvalid), v_t'(1));
        chk("lb_hold_data", v_t'({d_mlast, d_mdata}), prev_md);
      end
      if (d_mvalid && d_mready) chk("lb_beat", v_t'({d_mlast, 96'b0, d_mdata}), sb.pop_front());
      prev_hold = d_mvalid && !d_mready;
      prev_md = v_t'({d_mlast, d_mdata});
      @(negedge clk);
      cyc++;
    end
    chk("lb_drained", v_t'(sb.size()), v_t'(0));
    chk("lb_src_done", v_t'(d_done), v_t'(1));
    chk("lb_snk_done", v_t'(p_done), v_t'(1));
    chk("lb_src_err", v_t'(d_err), v_t'(0));
    chk("lb_snk_err", v_t'(p_err), v_t'(0));
    wb_read_chk(2, A_ERR, 32'h0, "lb_errreg");
    loop = 1'b0;
    sb.delete();

    // Sink, incr, seed 5, 4 beats, beat2 corrupted
    wb_write(1, A_CTRL, 32'h0);
    wb_write(1, A_SEED, 32'd5);
    wb_write(1, A_LEN, 32'd16);
    for (int b = 0; b < 4; b++) s_beat((b == 2) ? 32'hDEAD : 32'd5 + 32'(b), b == 3);
    chk("corrupt_err", v_t'(d_err), v_t'(1));
    chk("corrupt_done", v_t'(d_done), v_t'(1));
    wb_read_chk(1, A_ERR, 32'h0001_0002, "corrupt_errreg");

    // S_LAST wrongly asserted on beat1
    wb_write(1, A_SEED, 32'd5);
    wb_write(1, A_LEN, 32'd16);
    chk("rearm_err", v_t'(d_err), v_t'(0));
    for (int b = 0; b < 4; b++) s_beat(32'd5 + 32'(b), (b == 1) || (b == 3));
    wb_read_chk(1, A_ERR, 32'h0001_0001, "last_errreg");

    // Three extra beats after the transfer finished
    sv = 1'b1; sd = 32'd9; sl = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("extra_sready", v_t'(d_sready), v_t'(0));
      @(negedge clk);
    end
    sv = 1'b0;
    wb_read_chk(1, A_ERR, 32'h0004_0001, "extra_errreg");

    // Long extra-beat run saturates the counter
    sv = 1'b1;
    repeat (65600) @(negedge clk);
    sv = 1'b0;
    wb_read_chk(1, A_ERR, 32'hFFFF_0001, "sat_errreg");
    chk("sat_err", v_t'(d_err), v_t'(1));

    // Reset in the middle of a stalled source transfer
    wb_write(1, A_CTRL, 32'h8000_0000);
    wb_write(1, A_SEED, 32'h20);
    bm_ready = 1'b0;
    wb_write(1, A_LEN, 32'd64);
    chk("mid_valid", v_t'(d_mvalid), v_t'(1));
    chk("mid_data", v_t'(d_mdata), v_t'(32'h20));
    @(negedge clk);
    chk("mid_hold", v_t'(d_mvalid), v_t'(1));
    rst_a = 1'b1;
    @(negedge clk);
    chk("mrst_valid", v_t'(d_mvalid), v_t'(0));
    chk("mrst_data", v_t'(d_mdata), v_t'(0));
    chk("mrst_err", v_t'(d_err), v_t'(1));
    chk("mrst_sready", v_t'(d_sready), v_t'(0));
    chk("mrst_done", v_t'(d_done), v_t'(0));
    rst_a = 1'b0;
    @(negedge clk);
    wb_read_chk(1, A_LEN, 32'h0, "mrst_len");
    wb_read_chk(1, A_CTRL, 32'h0, "mrst_ctrl");
    wb_read_chk(1, A_SEED, 32'h1, "mrst_seed");
    wb_read_chk(1, A_ERR, 32'h0, "mrst_errreg");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
